// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_arbiter
// Purpose  : Two-port round-robin arbiter and access sequencer for the
//            byte-wide MIPS data memory. One 32-bit access is granted at a
//            time. It is split into four byte cycles in big-endian order, so
//            the MSB is at the lowest address. A one-cycle ack is returned on
//            completion.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            req/we/addr/wdata (0,1)    - word requests from the two masters
//            rdata (0,1), ack (0,1)     - read data and completion pulses
//            mem_addr/wdata/we/re/rdata - byte-wide memory array interface
//            busy, grant                - sequencer activity, owning port
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_LAST_BYTE = 2'd3;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant_now;
    logic                w_sel;
    logic [31:0]         w_addr_sel;
    logic                w_xfer;
    logic [7:0]          w_wbyte;

    logic [1:0]          r_cnt;
    logic                r_port;
    logic                r_we;
    logic [ADDR_W-1:0]   r_base;
    logic [31:0]         r_wdata;
    logic [31:8]         r_shadow;      // bytes 0..2 of a read; byte 3 is taken straight from mem_rdata
    logic                r_last_grant;
    logic [31:0]         r_rdata0;
    logic [31:0]         r_rdata1;

    // Word alignment and the address space size make these bits irrelevant.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{addr0[31:ADDR_W], addr0[1:0], addr1[31:ADDR_W], addr1[1:0]};

    // On a tie the port that did not win last time is chosen; otherwise the
    // lone requester wins (req1 alone selects port 1, req0 alone port 0).
    assign w_sel      = (req0 && req1) ? ~r_last_grant : req1;
    assign w_addr_sel = w_sel ? addr1 : addr0;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_now = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant_now = 1'b1;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (r_cnt == c_LAST_BYTE) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Access datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 2'd0;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_base       <= '0;
            r_wdata      <= 32'h0;
            r_shadow     <= 24'h0;
            r_last_grant <= 1'b1;
            r_rdata0     <= 32'h0;
            r_rdata1     <= 32'h0;
        end else begin
            if (w_grant_now) begin
                r_port  <= w_sel;
                r_we    <= w_sel ? we1 : we0;
                r_base  <= {w_addr_sel[ADDR_W-1:2], 2'b00};
                r_wdata <= w_sel ? wdata1 : wdata0;
                r_cnt   <= 2'd0;
            end
            if (r_state == S_XFER) begin
                r_cnt <= r_cnt + 2'd1;
                if (!r_we) begin
                    case (r_cnt)
                        2'd0:    r_shadow[31:24] <= mem_rdata;
                        2'd1:    r_shadow[23:16] <= mem_rdata;
                        2'd2:    r_shadow[15:8]  <= mem_rdata;
                        default: ;
                    endcase
                end
                if (r_cnt == c_LAST_BYTE) begin
                    r_last_grant <= r_port;
                    // The final byte arrives on this same edge, so it is
                    // merged directly into the visible read register.
                    if (!r_we) begin
                        if (r_port) begin
                            r_rdata1 <= {r_shadow, mem_rdata};
                        end else begin
                            r_rdata0 <= {r_shadow, mem_rdata};
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory-side strobes. Reset suppresses the strobes combinationally so
    // the byte in flight at the reset edge is not committed.
    // ------------------------------------------------------------------------
    always_comb begin
        w_wbyte = 8'h00;
        case (r_cnt)
            2'd0:    w_wbyte = r_wdata[31:24];
            2'd1:    w_wbyte = r_wdata[23:16];
            2'd2:    w_wbyte = r_wdata[15:8];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    assign w_xfer = (r_state == S_XFER) && !reset;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (w_xfer) begin
            // Wraps modulo 2^ADDR_W by construction.
            mem_addr = r_base + {{(ADDR_W-2){1'b0}}, r_cnt};
            if (r_we) begin
                mem_we    = 1'b1;
                mem_wdata = w_wbyte;
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    assign ack0   = (r_state == S_DONE) && !r_port;
    assign ack1   = (r_state == S_DONE) &&  r_port;
    assign busy   = (r_state != S_IDLE);
    assign grant  = r_port;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mem_arbiter
// Purpose  : Self-checking bench for mips_mem_arbiter. It has a byte-wide
//            memory behind the DUT, a vector table of single accesses,
//            directed contention and reset-abort sequences, and a randomized
//            phase checked against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int MEM_SZ = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, we0, we1;
    logic [31:0]       addr0, addr1, wdata0, wdata1;
    logic [31:0]       rdata0, rdata1;
    logic              ack0, ack1;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we, mem_re;
    logic [7:0]        mem_rdata;
    logic              busy, grant;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    // Byte memory array with a backdoor port for preload and clearing.
    logic [7:0]        mem [0:MEM_SZ-1];
    logic              bd_we, bd_clear;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_data;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (bd_clear) begin
            for (int i = 0; i < MEM_SZ; i++) mem[i] <= 8'h00;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference word-level memory for the random phase.
    logic [7:0] ref_mem [0:MEM_SZ-1];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd [2];
    bit          cur_grant;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_port(input bit p, input bit rq, input bit w,
                            input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            req1 = rq; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = rq; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic set_req(input bit p, input bit rq);
        if (p) req1 = rq;
        else   req0 = rq;
    endtask

    task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] a1, a2, a3;
        a1 = b + ADDR_W'(1); a2 = b + ADDR_W'(2); a3 = b + ADDR_W'(3);
        return {mem[b], mem[a1], mem[a2], mem[a3]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] a1, a2, a3;
        a1 = b + ADDR_W'(1); a2 = b + ADDR_W'(2); a3 = b + ADDR_W'(3);
        return {ref_mem[b], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a[ADDR_W-1:2] = '1;
        else                           a[ADDR_W-1:2] = 8'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " ack0"},      ack0,      32'h0);
        check({tag, " ack1"},      ack1,      32'h0);
        check({tag, " busy"},      busy,      32'h0);
        check({tag, " grant"},     grant,     32'h0);
        check({tag, " mem_we"},    mem_we,    32'h0);
        check({tag, " mem_re"},    mem_re,    32'h0);
        check({tag, " mem_addr"},  mem_addr,  32'h0);
        check({tag, " mem_wdata"}, mem_wdata, 32'h0);
        check({tag, " rdata0"},    rdata0,    32'h0);
        check({tag, " rdata1"},    rdata1,    32'h0);
    endtask

    // One uncontended access from idle: latency, strobe count, data, hold.
    task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_v,
                             input string name);
        int lat, we_cnt, other_ack;
        logic [ADDR_W-1:0] base;
        lat = 0; we_cnt = 0; other_ack = 0;
        base = {addr[ADDR_W-1:2], 2'b00};
        set_port(port, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (mem_we) we_cnt++;
            if (port ? ack0 : ack1) other_ack++;
            if (port ? ack1 : ack0) lat = c;
        end
        check({name, " ack latency"}, lat, 5);
        check({name, " other ack"}, other_ack, 0);
        check({name, " mem_we cycles"}, we_cnt, we ? 4 : 0);
        if (!we) exp_rd[port] = exp_v;
        check({name, " rdata0 at ack"}, rdata0, exp_rd[0]);
        check({name, " rdata1 at ack"}, rdata1, exp_rd[1]);
        cur_grant = port;
        set_req(port, 1'b0);
        tick();
        check({name, " busy after"}, busy, 0);
        check({name, " rdata hold"}, port ? rdata1 : rdata0, exp_rd[port]);
        if (we) check({name, " memory image"}, mem_word(base), wdata);
    endtask

    initial begin
        int          ack_n, mism;
        int          ack_tick [4];
        bit          ack_port [4];
        int          edge_n, m_next, m_g, k;
        bit          m_act, m_p, m_last, m_we_l, p, exp_xfer, exp_done;
        logic [ADDR_W-1:0] m_base, a;
        logic [31:0] m_wd, m_exp_read, exp_byte;
        logic [31:0] m_rd [2];

        reset = 1'b1; bd_we = 1'b0; bd_clear = 1'b1; bd_addr = '0; bd_data = 8'h00;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; cur_grant = 1'b0;

        tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0022, 32'h0,        32'h12345678};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0040, 32'hCAFEF00D, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        32'hCAFEF00D};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h11223344, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'hFFFF_F7FE, 32'h0,        32'h11223344};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_0400, 32'h55667788, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        32'h55667788};
        tbl[8] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,        32'hDEADBEEF};

        @(negedge clk);
        tick();
        bd_clear = 1'b0;
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;

        // Contention from reset: both held, grants must alternate 0,1,0,1.
        set_port(1'b0, 1'b1, 1'b1, 32'h80, 32'hA0A0A0A0);
        set_port(1'b1, 1'b1, 1'b1, 32'h90, 32'hB1B1B1B1);
        ack_n = 0;
        for (int c = 1; c <= 40 && ack_n < 4; c++) begin
            tick();
            if (ack0 && ack1) check("contention dual ack", 1, 0);
            if (ack0 || ack1) begin
                ack_tick[ack_n] = c;
                ack_port[ack_n] = ack1;
                ack_n++;
                if (ack_n == 4) begin req0 = 0; req1 = 0; end
            end
        end
        check("contention ack count", ack_n, 4);
        for (int i = 0; i < 4 && i < ack_n; i++) begin
            check($sformatf("contention ack%0d port", i), ack_port[i], i % 2);
            check($sformatf("contention ack%0d cycle", i), ack_tick[i], 5 + 6 * i);
        end
        tick();
        check("contention mem 0x80", mem_word(10'h080), 32'hA0A0A0A0);
        check("contention mem 0x90", mem_word(10'h090), 32'hB1B1B1B1);
        cur_grant = 1'b1;

        // Vector table of single accesses.
        bd_write(10'h020, 8'h12); bd_write(10'h021, 8'h34);
        bd_write(10'h022, 8'h56); bd_write(10'h023, 8'h78);
        for (int i = 0; i < 9; i++) begin
            do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                      tbl[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Reset during the third byte cycle of a write.
        bd_write(10'h052, 8'h5A); bd_write(10'h053, 8'hA5);
        set_port(1'b0, 1'b1, 1'b1, 32'h50, 32'hAABBCCDD);
        tick(); tick(); tick();
        check("abort mem_addr at cnt2", mem_addr, 32'h52);
        reset = 1'b1;
        tick();
        check_reset_outputs("abort");
        reset = 1'b0; req0 = 1'b0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; cur_grant = 1'b0;
        ack_n = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack0 || ack1) ack_n++;
        end
        check("abort no ack", ack_n, 0);
        check("abort memory image", mem_word(10'h050), 32'hAABB5AA5);
        do_access(1'b0, 1'b1, 32'h50, 32'h01020304, 32'h0, "post-abort wr");
        do_access(1'b1, 1'b0, 32'h51, 32'h0, 32'h01020304, "post-abort rd");

        // Randomized phase against the word-level model.
        bd_clear = 1'b1; tick(); bd_clear = 1'b0;
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = 8'h00;
        m_rd[0] = exp_rd[0]; m_rd[1] = exp_rd[1];
        m_p = cur_grant; m_last = cur_grant; m_act = 0; m_we_l = 0;
        m_base = '0; m_wd = 0; m_exp_read = 0;
        edge_n = 0; m_next = 0; m_g = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (edge_n >= m_next && (req0 || req1)) begin
                p      = (req0 && req1) ? ~m_last : req1;
                m_p    = p; m_last = p; m_act = 1; m_g = edge_n; m_next = edge_n + 6;
                m_we_l = p ? we1 : we0;
                m_base = p ? {addr1[ADDR_W-1:2], 2'b00} : {addr0[ADDR_W-1:2], 2'b00};
                m_wd   = p ? wdata1 : wdata0;
                if (m_we_l) begin
                    for (int i = 0; i < 4; i++) begin
                        a = m_base + ADDR_W'(i);
                        ref_mem[a] = 8'(m_wd >> (24 - 8 * i));
                    end
                end else begin
                    m_exp_read = ref_word(m_base);
                end
            end
            tick();
            k        = edge_n - m_g;
            exp_xfer = m_act && k >= 0 && k <= 3;
            exp_done = m_act && k == 4;
            if (exp_done && !m_we_l) m_rd[m_p] = m_exp_read;
            exp_byte = exp_xfer && m_we_l ? ((m_wd >> (24 - 8 * k)) & 32'hFF) : 32'h0;
            check("rnd ack0",      ack0,      exp_done && !m_p);
            check("rnd ack1",      ack1,      exp_done && m_p);
            check("rnd busy",      busy,      exp_xfer || exp_done);
            check("rnd grant",     grant,     m_p);
            check("rnd mem_we",    mem_we,    exp_xfer && m_we_l);
            check("rnd mem_re",    mem_re,    exp_xfer && !m_we_l);
            check("rnd mem_addr",  mem_addr,  exp_xfer ? 32'(ADDR_W'(m_base + ADDR_W'(k))) : 32'h0);
            check("rnd mem_wdata", mem_wdata, exp_byte);
            check("rnd rdata0",    rdata0,    m_rd[0]);
            check("rnd rdata1",    rdata1,    m_rd[1]);
            if (exp_done) set_req(m_p, 1'b0);
            for (int q = 0; q < 2; q++) begin
                if (!(q ? req1 : req0) && $urandom_range(0, 2) == 0) begin
                    set_port(q[0], 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end
            end
            edge_n++;
        end
        req0 = 0; req1 = 0;
        for (int c = 0; c < 8; c++) tick();
        mism = 0;
        for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("rnd final memory image mismatching bytes", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
